// File: rtl/of_ex_if.sv
// OF -> EX pipeline-register bus: OF-stage operands and forwarding flags in, EX-stage state and stall out.
// master = operand-fetch side driving the register, slave = of_ex_latch.
interface of_ex_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] of_ir_i;
  logic [DATA_W-1:0] of_pc_i;
  logic [DATA_W-1:0] rf_a_i;
  logic [DATA_W-1:0] rf_b_i;
  logic [DATA_W-1:0] rw_result_i;
  logic              fwd_rw_of_src1_i;
  logic              fwd_rw_of_src2_i;
  logic              flush_i;
  logic              stall_o;
  logic [DATA_W-1:0] ex_ir_o;
  logic [DATA_W-1:0] ex_pc_o;
  logic [DATA_W-1:0] ex_a_o;
  logic [DATA_W-1:0] ex_b_o;
  logic [DATA_W-1:0] ex_op2_o;
  logic              ex_valid_o;

  modport master (
    output of_ir_i, of_pc_i, rf_a_i, rf_b_i, rw_result_i,
    output fwd_rw_of_src1_i, fwd_rw_of_src2_i, flush_i,
    input  stall_o, ex_ir_o, ex_pc_o, ex_a_o, ex_b_o, ex_op2_o, ex_valid_o
  );

  modport slave (
    input  of_ir_i, of_pc_i, rf_a_i, rf_b_i, rw_result_i,
    input  fwd_rw_of_src1_i, fwd_rw_of_src2_i, flush_i,
    output stall_o, ex_ir_o, ex_pc_o, ex_a_o, ex_b_o, ex_op2_o, ex_valid_o
  );
endinterface

// File: rtl/of_ex_latch.sv
// OF/EX pipeline register for SimpleRISC: operand select, load-use detection, bubble insertion.
// Optional macro OF_EX_BUBBLE_CNT_EN adds a saturating bubble counter output bubble_cnt_o.
module of_ex_latch #(
  parameter int DATA_W = 32,
  parameter int RA_IDX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  of_ex_if.slave      bus
`ifdef OF_EX_BUBBLE_CNT_EN
  ,
  output logic [31:0] bubble_cnt_o
`endif
);

  localparam logic [DATA_W-1:0] NOP_IR = DATA_W'(32'h6800_0000);
  localparam logic [3:0] RA_REG = 4'(RA_IDX);
  localparam logic [4:0] OP_NOP = 5'b01101, OP_B   = 5'b10010, OP_BEQ = 5'b10000,
                         OP_BGT = 5'b10001, OP_CALL = 5'b10011, OP_MOV = 5'b01001,
                         OP_NOT = 5'b01000, OP_RET = 5'b10100, OP_ST  = 5'b01111,
                         OP_LD  = 5'b01110;

  logic [4:0]        of_op;
  logic              of_i;
  logic [3:0]        of_rd, of_rs1, of_rs2, src2_reg;
  logic [1:0]        modifier;
  logic [15:0]       imm16;
  logic              is_st, is_ld, is_ret;
  logic              reads_src1, reads_src2;
  logic [DATA_W-1:0] imm_ext, src2_val, op_a, op_b;
  logic [4:0]        ex_op;
  logic [3:0]        ex_rd;
  logic              load_use, bubble;

  assign of_op    = bus.of_ir_i[31:27];
  assign of_i     = bus.of_ir_i[26];
  assign of_rd    = bus.of_ir_i[25:22];
  assign of_rs1   = bus.of_ir_i[21:18];
  assign of_rs2   = bus.of_ir_i[17:14];
  assign modifier = bus.of_ir_i[17:16];
  assign imm16    = bus.of_ir_i[15:0];
  assign ex_op    = bus.ex_ir_o[31:27];
  assign ex_rd    = bus.ex_ir_o[25:22];

  assign is_st  = (of_op == OP_ST);
  assign is_ld  = (of_op == OP_LD);
  assign is_ret = (of_op == OP_RET);

  assign reads_src1 = !(of_op inside {OP_NOP, OP_B, OP_BEQ, OP_BGT, OP_CALL, OP_MOV, OP_NOT, OP_RET});
  assign reads_src2 = is_st || is_ret ||
                      (!of_i && !(of_op inside {OP_NOP, OP_B, OP_BEQ, OP_BGT, OP_CALL, OP_LD}));
  assign src2_reg   = is_st ? of_rd : (is_ret ? RA_REG : of_rs2);

  always_comb begin
    imm_ext = {{(DATA_W-16){imm16[15]}}, imm16};
    case (modifier)
      2'b01:   imm_ext = DATA_W'(imm16);
      2'b10:   imm_ext = DATA_W'({imm16, 16'h0000});
      default: imm_ext = {{(DATA_W-16){imm16[15]}}, imm16};
    endcase
  end

  assign src2_val = bus.fwd_rw_of_src2_i ? bus.rw_result_i : bus.rf_b_i;
  assign op_a     = bus.fwd_rw_of_src1_i ? bus.rw_result_i : bus.rf_a_i;
  assign op_b     = (of_i || is_ld || is_st) ? imm_ext : src2_val;

  // A store whose data register is the load target is covered by RW->MA forwarding.
  assign load_use = bus.ex_valid_o && (ex_op == OP_LD) &&
                    ((reads_src1 && (of_rs1 == ex_rd)) ||
                     (reads_src2 && !is_st && (src2_reg == ex_rd)));

  // Handshake: stall_o=1 means OF is not consumed this edge and must be held upstream;
  // ex_valid_o=1 means EX holds a real instruction, 0 means bubble or nop.
  assign bus.stall_o = load_use && !bus.flush_i;
  assign bubble      = bus.flush_i || bus.stall_o;

  always_ff @(posedge clk) begin
    if (!rst_n || bubble) begin
      bus.ex_ir_o    <= NOP_IR;
      bus.ex_pc_o    <= '0;
      bus.ex_a_o     <= '0;
      bus.ex_b_o     <= '0;
      bus.ex_op2_o   <= '0;
      bus.ex_valid_o <= 1'b0;
    end else begin
      bus.ex_ir_o    <= bus.of_ir_i;
      bus.ex_pc_o    <= bus.of_pc_i;
      bus.ex_a_o     <= op_a;
      bus.ex_b_o     <= op_b;
      bus.ex_op2_o   <= src2_val;
      bus.ex_valid_o <= (of_op != OP_NOP);
    end
  end

`ifdef OF_EX_BUBBLE_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      bubble_cnt_o <= '0;
    else if (bubble && (bubble_cnt_o != 32'hFFFF_FFFF))
      bubble_cnt_o <= bubble_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_of_ex_latch.sv
// Directed table-driven bench for of_ex_latch: operand select, immediates, load-use, flush, reset.
module tb_of_ex_latch;

  localparam logic [31:0] NOP = 32'h6800_0000;
  localparam logic [4:0] ADD = 5'b00000, MOV = 5'b01001, LD = 5'b01110,
                         ST  = 5'b01111, RET = 5'b10100;

  logic clk = 1'b0;
  logic rst_n;
  of_ex_if #(.DATA_W(32)) bus ();
`ifdef OF_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  of_ex_latch #(.DATA_W(32), .RA_IDX(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef OF_EX_BUBBLE_CNT_EN
    ,
    .bubble_cnt_o (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir, pc, ra, rb, rw;
    logic        f1, f2, fl;
    logic        e_stall, e_bub;
    logic [31:0] e_a, e_b, e_op2;
  } vec_t;

  vec_t vq[$];
  int n_vec = 0, n_cmp = 0, n_err = 0;
  logic [31:0] exp_cnt = 0;

  function automatic logic [31:0] enc(logic [4:0] op, logic i, logic [3:0] rd,
                                      logic [3:0] rs1, logic [17:0] imm);
    return {op, i, rd, rs1, imm};
  endfunction

  task automatic add_vec(input logic [31:0] ir, input logic [31:0] ra, input logic [31:0] rb,
                         input logic [31:0] rw, input logic f1, input logic f2, input logic fl,
                         input logic e_stall, input logic e_bub, input logic [31:0] e_a,
                         input logic [31:0] e_b, input logic [31:0] e_op2);
    vec_t v;
    v.ir = ir; v.pc = 32'h100 + 32'(vq.size() * 4); v.ra = ra; v.rb = rb; v.rw = rw;
    v.f1 = f1; v.f2 = f2; v.fl = fl; v.e_stall = e_stall; v.e_bub = e_bub;
    v.e_a = e_a; v.e_b = e_b; v.e_op2 = e_op2;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.of_ir_i = v.ir; bus.of_pc_i = v.pc; bus.rf_a_i = v.ra; bus.rf_b_i = v.rb;
    bus.rw_result_i = v.rw; bus.fwd_rw_of_src1_i = v.f1;
    bus.fwd_rw_of_src2_i = v.f2; bus.flush_i = v.fl;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".ir"}, bus.ex_ir_o, NOP);
    chk({tag, ".pc"}, bus.ex_pc_o, 0);
    chk({tag, ".a"}, bus.ex_a_o, 0);
    chk({tag, ".b"}, bus.ex_b_o, 0);
    chk({tag, ".op2"}, bus.ex_op2_o, 0);
    chk({tag, ".valid"}, 32'(bus.ex_valid_o), 0);
    chk({tag, ".stall"}, 32'(bus.stall_o), 0);
`ifdef OF_EX_BUBBLE_CNT_EN
    chk({tag, ".cnt"}, bubble_cnt, 0);
`endif
  endtask

  initial begin
    vec_t v;
    // add r3,r1,r2 with forwarding variants
    add_vec(enc(ADD,0,3,1,18'(2<<14)), 5, 7, 0,  0,0,0, 0,0, 5,  7, 7);
    add_vec(enc(ADD,0,3,1,18'(2<<14)), 5, 7, 9,  0,1,0, 0,0, 5,  9, 9);
    add_vec(enc(ADD,0,3,1,18'(2<<14)), 5, 7, 11, 1,0,0, 0,0, 11, 7, 7);
    // immediate modifiers
    add_vec(enc(ADD,1,3,1,18'h0FFFE), 5, 7, 0, 0,0,0, 0,0, 5, 32'hFFFF_FFFE, 7);
    add_vec(enc(ADD,1,3,1,18'h1FFFE), 5, 7, 0, 0,0,0, 0,0, 5, 32'h0000_FFFE, 7);
    add_vec(enc(ADD,1,3,1,18'h20012), 5, 7, 0, 0,0,0, 0,0, 5, 32'h0012_0000, 7);
    add_vec(enc(ADD,1,3,1,18'h38001), 5, 7, 0, 0,0,0, 0,0, 5, 32'hFFFF_8001, 7);
    // load-use on add rs1, then replay
    add_vec(enc(LD,1,4,1,0),           'h40, 3, 0, 0,0,0, 0,0, 'h40, 0, 3);
    add_vec(enc(ADD,0,5,4,18'(2<<14)), 6, 8, 0, 0,0,0, 1,1, 0, 0, 0);
    add_vec(enc(ADD,0,5,4,18'(2<<14)), 6, 8, 0, 0,0,0, 0,0, 6, 8, 8);
    // store whose data reg is the load target: no stall
    add_vec(enc(LD,1,4,1,0), 'h40, 3,  0, 0,0,0, 0,0, 'h40, 0, 3);
    add_vec(enc(ST,1,4,1,0), 'h50, 77, 0, 0,0,0, 0,0, 'h50, 0, 77);
    // store whose address reg is the load target: stall
    add_vec(enc(LD,1,4,2,8), 'h60, 1, 0, 0,0,0, 0,0, 'h60, 8, 1);
    add_vec(enc(ST,1,1,4,0), 'h70, 2, 0, 0,0,0, 1,1, 0, 0, 0);
    add_vec(enc(ST,1,1,4,0), 'h70, 2, 0, 0,0,0, 0,0, 'h70, 0, 2);
    // flush beats load-use, then a nop loads with valid=0
    add_vec(enc(LD,1,4,1,0),           'h40, 3, 0, 0,0,0, 0,0, 'h40, 0, 3);
    add_vec(enc(ADD,0,5,4,18'(2<<14)), 6, 8, 0, 0,0,1, 0,1, 0, 0, 0);
    add_vec(NOP,                       1, 2, 0, 0,0,0, 0,0, 1, 2, 2);
    // back-to-back dependent loads, then dependent add
    add_vec(enc(LD,1,4,1,0),            'h40, 3, 0, 0,0,0, 0,0, 'h40, 0, 3);
    add_vec(enc(LD,1,6,4,4),            'h90, 5, 0, 0,0,0, 1,1, 0, 0, 0);
    add_vec(enc(LD,1,6,4,4),            'h90, 5, 0, 0,0,0, 0,0, 'h90, 4, 5);
    add_vec(enc(ADD,0,7,6,18'(6<<14)),  11, 12, 0, 0,0,0, 1,1, 0, 0, 0);
    add_vec(enc(ADD,0,7,6,18'(6<<14)),  11, 12, 0, 0,0,0, 0,0, 11, 12, 12);
    // mov immediate does not read rs1 field
    add_vec(enc(LD,1,4,1,0),  'h40, 3, 0, 0,0,0, 0,0, 'h40, 0, 3);
    add_vec(enc(MOV,1,5,4,4), 13, 14, 0, 0,0,0, 0,0, 13, 4, 14);
    // ret reads ra (r15)
    add_vec(enc(LD,1,15,1,0), 'h40, 3, 0, 0,0,0, 0,0, 'h40, 0, 3);
    add_vec(enc(RET,0,0,0,0), 21, 22, 0, 0,0,0, 1,1, 0, 0, 0);
    add_vec(enc(RET,0,0,0,0), 21, 22, 0, 0,0,0, 0,0, 21, 22, 22);
    // rs2 match on register-form add
    add_vec(enc(LD,1,4,1,0),           'h40, 3, 0, 0,0,0, 0,0, 'h40, 0, 3);
    add_vec(enc(ADD,0,5,1,18'(4<<14)), 1, 2, 0, 0,0,0, 1,1, 0, 0, 0);
    add_vec(enc(ADD,0,5,1,18'(4<<14)), 1, 2, 0, 0,0,0, 0,0, 1, 2, 2);

    // reset with arbitrary inputs
    rst_n = 1'b0;
    v.ir = $urandom; v.pc = $urandom; v.ra = $urandom; v.rb = $urandom; v.rw = $urandom;
    v.f1 = 1'($urandom_range(0,1)); v.f2 = 1'($urandom_range(0,1)); v.fl = 1'($urandom_range(0,1));
    drive(v);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst_n = 1'b1;

    foreach (vq[k]) begin
      string nm;
      logic [31:0] e_ir, e_pc, e_a, e_b, e_op2, e_valid;
      v = vq[k];
      nm = $sformatf("v%0d", k);
      drive(v);
      #1;
      chk({nm, ".stall"}, 32'(bus.stall_o), 32'(v.e_stall));
      @(posedge clk);
      #1;
      n_vec++;
      e_ir    = v.e_bub ? NOP : v.ir;
      e_pc    = v.e_bub ? 0 : v.pc;
      e_a     = v.e_bub ? 0 : v.e_a;
      e_b     = v.e_bub ? 0 : v.e_b;
      e_op2   = v.e_bub ? 0 : v.e_op2;
      e_valid = (v.e_bub || v.ir[31:27] == 5'b01101) ? 0 : 1;
      if (v.e_bub) exp_cnt++;
      chk({nm, ".ir"}, bus.ex_ir_o, e_ir);
      chk({nm, ".pc"}, bus.ex_pc_o, e_pc);
      chk({nm, ".a"}, bus.ex_a_o, e_a);
      chk({nm, ".b"}, bus.ex_b_o, e_b);
      chk({nm, ".op2"}, bus.ex_op2_o, e_op2);
      chk({nm, ".valid"}, 32'(bus.ex_valid_o), e_valid);
`ifdef OF_EX_BUBBLE_CNT_EN
      chk({nm, ".cnt"}, bubble_cnt, exp_cnt);
`endif
    end

    // reset asserted during a load-use stall
    v.ir = enc(LD,1,4,1,0); v.pc = 32'h400; v.ra = 32'h40; v.rb = 3; v.rw = 0;
    v.f1 = 0; v.f2 = 0; v.fl = 0;
    drive(v);
    @(posedge clk);
    #1;
    v.ir = enc(ADD,0,5,4,18'(2<<14)); v.pc = 32'h404; v.ra = 6; v.rb = 8;
    drive(v);
    #1;
    chk("midrst.pre_stall", 32'(bus.stall_o), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    chk_reset_state("midrst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    chk("midrst.release.ir", bus.ex_ir_o, v.ir);
    chk("midrst.release.a", bus.ex_a_o, 6);
    chk("midrst.release.valid", 32'(bus.ex_valid_o), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/of_ex_latch.md
Name: of_ex_latch

Overview:
- OF/EX pipeline register for the 5-stage SimpleRISC pipeline. Sits between the operand-fetch stage and EX.
- Picks the final operand A, operand B and store data for the instruction in OF. Uses the RW->OF forwarding flags from the src1/src2 forwarding units.
- Detects load-use hazards against the instruction in EX. Inserts bubbles on stall or branch flush.

Parameters:
- DATA_W, 32, datapath width (operands, PC, IR).
- RA_IDX, 15, register index of ra (used by call/ret).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- of_ir_i  input  DATA_W  instruction in OF.
- of_pc_i  input  DATA_W  PC of OF instruction.
- rf_a_i  input  DATA_W  register-file read, src1 port.
- rf_b_i  input  DATA_W  register-file read, src2 port (rs2 / rd for st / ra for ret).
- rw_result_i  input  DATA_W  writeback value currently in RW.
- fwd_rw_of_src1_i  input  1  RW->OF conflict on src1.
- fwd_rw_of_src2_i  input  1  RW->OF conflict on src2 (is_RW_OF_conflict_src2).
- flush_i  input  1  branch taken in EX; kill OF.
- stall_o  output  1  combinational; freeze IF/OF this cycle.
- ex_ir_o  output  DATA_W  registered IR to EX.
- ex_pc_o  output  DATA_W  registered PC.
- ex_a_o  output  DATA_W  registered operand A.
- ex_b_o  output  DATA_W  registered operand B (immediate or register).
- ex_op2_o  output  DATA_W  registered store data / ret target.
- ex_valid_o  output  1  EX holds a real instruction.

Behaviour:
Field decode:
- opcode = ir[31:27], I = ir[26], rd = ir[25:22], rs1 = ir[21:18], rs2 = ir[17:14], imm = ir[17:0], modifier = ir[17:16].
- NOP encoding = 32'h6800_0000 (opcode 01101).

Source-register rules:
- reads_src1: false for nop(01101), b(10010), beq(10000), bgt(10001), call(10011), mov(01001), not(01000), ret(10100).
- src2 register: rd for st(01111); RA_IDX for ret; else rs2.
- reads_src2: true for st and ret; for all other opcodes, I==0 and opcode not in {nop, b, beq, bgt, call, ld}.

Immediate (ex_b when I==1, st and ld excluded from that rule only as noted below):
- modifier 00: sign-extend imm[15:0].
- modifier 01: zero-extend imm[15:0].
- modifier 10: {imm[15:0], 16'h0}.
- modifier 11: treated as 00.

Operand select, combinational, registered at the edge:
- A = fwd_rw_of_src1_i ? rw_result_i : rf_a_i.
- src2val = fwd_rw_of_src2_i ? rw_result_i : rf_b_i.
- B = I ? imm_ext : src2val. For ld and st, B = imm_ext regardless of I.
- op2 = src2val.

Load-use hazard:
- Raised when ex_valid_o, EX opcode == ld (01110), and ex rd matches either:
  - OF rs1 with reads_src1, or
  - OF src2 register with reads_src2, excluding the case where OF is st and only its rd matches (RW->MA forwarding covers it).

Outputs:
- stall_o = load_use & ~flush_i. Combinational, no latency.

Register update every rising edge, in priority order:
1. rst_n==0: ex_ir_o=NOP, ex_pc_o=0, ex_a_o=0, ex_b_o=0, ex_op2_o=0, ex_valid_o=0.
2. flush_i: load bubble (ex_ir_o=NOP, ex_valid_o=0; ex_pc_o/ex_a_o/ex_b_o/ex_op2_o=0).
3. stall_o: load bubble. Upstream holds OF, so the same instruction is re-evaluated next cycle.
4. Otherwise: load OF values. ex_valid_o = (OF opcode != nop).

Boundary cases:
- Flush and load-use in the same cycle: flush wins, stall_o=0.
- A stall lasts exactly one cycle per load: after the bubble, EX holds NOP, so the hazard clears.
- Back-to-back loads feeding each other: one bubble per dependent pair.
- Reset asserted mid-stall: outputs go to reset values at that edge; stall_o=0 while EX is the reset NOP.

Optional Feature:
- Macro: OF_EX_BUBBLE_CNT_EN.
- With it defined:
  - Adds output bubble_cnt_o [31:0], reset 0.
  - Increments by 1 on every edge that loads a bubble due to stall_o or flush_i. Saturates at 32'hFFFF_FFFF.
- Without it: port and counter absent; all other behaviour identical.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with arbitrary inputs -> ex_ir_o=32'h6800_0000, ex_valid_o=0, all data outputs 0, stall_o=0.
2. add r3,r1,r2 (I=0), rf_a=5, rf_b=7, both fwd=0 -> next edge ex_a=5, ex_b=7, ex_valid=1. Repeat with fwd_rw_of_src2_i=1, rw_result=9 -> ex_b=9.
3. Immediates: addi modifier 00, imm16=16'hFFFE -> ex_b=32'hFFFF_FFFE; modifier 01 -> 32'h0000_FFFE; modifier 10, 16'h0012 -> 32'h0012_0000.
4. Load-use: EX=ld r4,[r1+0], OF=add r5,r4,r2 -> stall_o=1, next ex_ir=NOP, ex_valid=0; following edge loads the add. With OF=st r4,[r1+0] instead -> no stall.
5. Flush priority: load-use condition present and flush_i=1 -> stall_o=0, bubble loaded. With OF_EX_BUBBLE_CNT_EN defined, bubble_cnt_o increments by exactly 1.
6. Mid-stall reset: assert rst_n=0 during the stall cycle -> next edge reset values, stall_o=0, bubble_cnt_o=0.
